// File: rtl/pc_sequencer.sv
// LC-3 instruction sequencer: fetch, decode and PC-changing opcodes.
// Non-control opcodes are handed to the execute unit via exec_start/exec_done.
module pc_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      ir,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    input  logic             mem_ready,
    input  logic             exec_done,
    output logic             ldPC,
    output logic [1:0]       selPC,
    output logic             gatePC,
    output logic             gateMDR,
    output logic             gateTrapVec,
    output logic             ldMAR,
    output logic             ldMDR,
    output logic             ldIR,
    output logic             ldR7,
    output logic             mem_en,
    output logic             exec_start,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    typedef enum logic [4:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC,
        S_BR, S_JMP, S_J0, S_J1,
        S_T0, S_T1, S_T2, S_T3,
        S_EX, S_EW, S_DONE, S_ILL
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [WW-1:0] wait_cnt;
    logic          mem_wait;
    logic          timeout;
    logic          br_take;

    assign mem_wait = (state == S_F1) || (state == S_T2);
    assign br_take  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    // wait_cnt holds the number of not-ready cycles already spent in this wait
    assign timeout  = (MEM_WAIT_MAX != 0) && mem_wait && !mem_ready &&
                      (int'(wait_cnt) == MEM_WAIT_MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_nx;
            if (mem_wait && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == S_DONE) begin
                retired <= retired + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (run) state_nx = S_F0;
            S_F0:   state_nx = S_F1;
            S_F1: begin
                if (mem_ready)    state_nx = S_F2;
                else if (timeout) state_nx = S_IDLE;
            end
            S_F2:   state_nx = S_DEC;
            S_DEC: begin
                unique case (ir[15:12])
                    4'b0000:          state_nx = br_take ? S_BR : S_DONE;
                    4'b1100:          state_nx = S_JMP;
                    4'b0100:          state_nx = S_J0;
                    4'b1111:          state_nx = S_T0;
                    4'b1000, 4'b1101: state_nx = S_ILL;
                    default:          state_nx = S_EX;
                endcase
            end
            S_BR:   state_nx = S_DONE;
            S_JMP:  state_nx = S_DONE;
            S_J0:   state_nx = S_J1;
            S_J1:   state_nx = S_DONE;
            S_T0:   state_nx = S_T1;
            S_T1:   state_nx = S_T2;
            S_T2: begin
                if (mem_ready)    state_nx = S_T3;
                else if (timeout) state_nx = S_IDLE;
            end
            S_T3:   state_nx = S_DONE;
            S_EX:   state_nx = S_EW;
            S_EW:   if (exec_done) state_nx = S_DONE;
            S_DONE: state_nx = run ? S_F0 : S_IDLE;
            S_ILL:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ldPC        = 1'b0;
        selPC       = 2'b00;
        gatePC      = 1'b0;
        gateMDR     = 1'b0;
        gateTrapVec = 1'b0;
        ldMAR       = 1'b0;
        ldMDR       = 1'b0;
        ldIR        = 1'b0;
        ldR7        = 1'b0;
        mem_en      = 1'b0;
        exec_start  = 1'b0;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        unique case (state)
            S_F0: begin
                gatePC = 1'b1;
                ldMAR  = 1'b1;
                ldPC   = 1'b1;
            end
            S_F1, S_T2: begin
                mem_en  = 1'b1;
                ldMDR   = mem_ready;
                mem_err = timeout;
            end
            S_F2: begin
                gateMDR = 1'b1;
                ldIR    = 1'b1;
            end
            S_BR: begin
                ldPC  = 1'b1;
                selPC = 2'b01;
            end
            S_JMP: begin
                ldPC  = 1'b1;
                selPC = 2'b10;
            end
            S_J0, S_T0: begin
                gatePC = 1'b1;
                ldR7   = 1'b1;
            end
            S_J1: begin
                ldPC  = 1'b1;
                selPC = ir[11] ? 2'b01 : 2'b10;
            end
            S_T1: begin
                gateTrapVec = 1'b1;
                ldMAR       = 1'b1;
            end
            S_T3: begin
                gateMDR = 1'b1;
                ldPC    = 1'b1;
                selPC   = 2'b10;
            end
            S_EX:  exec_start = 1'b1;
            S_ILL: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-opcode vector table plus
// hand-written memory-wait, timeout, wrap and reset sequences.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_ready;
    logic        exec_done;
    logic        ldPC;
    logic [1:0]  selPC;
    logic        gatePC, gateMDR, gateTrapVec;
    logic        ldMAR, ldMDR, ldIR, ldR7;
    logic        mem_en, exec_start, illegal_op, mem_err;
    logic [15:0] retired;

    logic        w_ldPC;
    logic [1:0]  w_selPC;
    logic        w_gatePC, w_gateMDR, w_gateTrapVec;
    logic        w_ldMAR, w_ldMDR, w_ldIR, w_ldR7;
    logic        w_mem_en, w_exec_start, w_illegal_op, w_mem_err;
    logic [2:0]  w_retired;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir),
        .n(n), .z(z), .p(p),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .ldPC(ldPC), .selPC(selPC), .gatePC(gatePC),
        .gateMDR(gateMDR), .gateTrapVec(gateTrapVec),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR), .ldR7(ldR7),
        .mem_en(mem_en), .exec_start(exec_start),
        .illegal_op(illegal_op), .mem_err(mem_err),
        .retired(retired)
    );

    // Narrow counter instance to reach the wrap point quickly
    pc_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .run(run), .ir(ir),
        .n(n), .z(z), .p(p),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .ldPC(w_ldPC), .selPC(w_selPC), .gatePC(w_gatePC),
        .gateMDR(w_gateMDR), .gateTrapVec(w_gateTrapVec),
        .ldMAR(w_ldMAR), .ldMDR(w_ldMDR), .ldIR(w_ldIR), .ldR7(w_ldR7),
        .mem_en(w_mem_en), .exec_start(w_exec_start),
        .illegal_op(w_illegal_op), .mem_err(w_mem_err),
        .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ed_cnt = 0;

    logic [13:0] outs;
    assign outs = {ldPC, selPC, gatePC, gateMDR, gateTrapVec, ldMAR,
                   ldMDR, ldIR, ldR7, mem_en, exec_start, illegal_op, mem_err};

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [2:0]  nzp;
        int          lat;
        int          ldpc;
        logic [1:0]  sel;
        int          r7;
        int          exs;
        int          trap;
        int          ill;
        int          ret;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and run the exec_done responder:
    // exec_done rises in the second EW cycle after exec_start.
    task automatic tick();
        @(negedge clk);
        if (ed_cnt > 0) begin
            ed_cnt--;
            exec_done = (ed_cnt == 0);
        end else begin
            exec_done = 1'b0;
        end
        if (exec_start) ed_cnt = 2;
    endtask

    function automatic logic is_f0();
        return gatePC && ldMAR && ldPC;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b1;
        exec_done = 1'b0;
        ed_cnt    = 0;
        ir        = 16'h0000;
        {n, z, p} = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_for_start(input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (exec_start) hit = 1'b1;
        end
        chk(name, hit, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"add",      16'h1021, 3'b000, 8, 1, 2'b00, 0, 1, 0, 0, 1};
        vecs[1]  = '{"ld",       16'h2005, 3'b010, 8, 1, 2'b00, 0, 1, 0, 0, 1};
        vecs[2]  = '{"brnzp_n",  16'h0E05, 3'b100, 6, 2, 2'b01, 0, 0, 0, 0, 1};
        vecs[3]  = '{"brnzp_z",  16'h0E05, 3'b010, 6, 2, 2'b01, 0, 0, 0, 0, 1};
        vecs[4]  = '{"brnzp_0",  16'h0E05, 3'b000, 5, 1, 2'b00, 0, 0, 0, 0, 1};
        vecs[5]  = '{"brn_z",    16'h0805, 3'b010, 5, 1, 2'b00, 0, 0, 0, 0, 1};
        vecs[6]  = '{"brp_p",    16'h0200, 3'b001, 6, 2, 2'b01, 0, 0, 0, 0, 1};
        vecs[7]  = '{"ret",      16'hC1C0, 3'b000, 6, 2, 2'b10, 0, 0, 0, 0, 1};
        vecs[8]  = '{"jsr",      16'h4805, 3'b000, 7, 2, 2'b01, 1, 0, 0, 0, 1};
        vecs[9]  = '{"jsrr",     16'h4080, 3'b000, 7, 2, 2'b10, 1, 0, 0, 0, 1};
        vecs[10] = '{"trap",     16'hF025, 3'b000, 9, 2, 2'b10, 1, 0, 1, 0, 1};
        vecs[11] = '{"rti",      16'h8000, 3'b000, 6, 1, 2'b00, 0, 0, 0, 1, 0};
        vecs[12] = '{"reserved", 16'hD000, 3'b000, 6, 1, 2'b00, 0, 0, 0, 1, 0};

        // Reset state
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        exec_done = 1'b0;
        ir        = 16'h0000;
        {n, z, p} = 3'b000;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(outs), 0);
        chk("reset_retired", 32'(retired), 0);

        // Opcode table: one instruction from F0 to the next F0
        for (int v = 0; v < 13; v++) begin
            logic        found;
            logic [1:0]  last_sel;
            logic [15:0] ret0;
            int lat, ldpc_n, r7_n, exs_n, trap_n, ill_n;
            do_reset();
            ir        = vecs[v].ir;
            {n, z, p} = vecs[v].nzp;
            run       = 1'b1;
            found     = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                if (is_f0()) found = 1'b1;
            end
            chk({vecs[v].name, "_f0"}, found, 1);
            ret0 = retired;
            lat = 0; ldpc_n = 0; r7_n = 0; exs_n = 0; trap_n = 0; ill_n = 0;
            last_sel = 2'b11;
            do begin
                if (ldPC) begin
                    ldpc_n++;
                    last_sel = selPC;
                end
                r7_n   += int'(ldR7);
                exs_n  += int'(exec_start);
                trap_n += int'(gateTrapVec);
                ill_n  += int'(illegal_op);
                lat++;
                tick();
            end while (!is_f0() && lat < 40);
            chk({vecs[v].name, "_latency"}, lat, vecs[v].lat);
            chk({vecs[v].name, "_ldpc"}, ldpc_n, vecs[v].ldpc);
            chk({vecs[v].name, "_sel"}, 32'(last_sel), 32'(vecs[v].sel));
            chk({vecs[v].name, "_ldr7"}, r7_n, vecs[v].r7);
            chk({vecs[v].name, "_exec_start"}, exs_n, vecs[v].exs);
            chk({vecs[v].name, "_trapvec"}, trap_n, vecs[v].trap);
            chk({vecs[v].name, "_illegal"}, ill_n, vecs[v].ill);
            chk({vecs[v].name, "_retired"}, 32'(retired - ret0), vecs[v].ret);
        end

        // TRAP with mem_ready arriving in the third T2 cycle
        begin
            logic hit;
            do_reset();
            ir  = 16'hF025;
            run = 1'b1;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                tick();
                if (gateTrapVec) hit = 1'b1;
            end
            chk("trap_t1_seen", hit, 1);
            chk("trap_t1_ldmar", ldMAR, 1);
            mem_ready = 1'b0;
            tick();
            chk("trap_t2a", {mem_en, ldMDR}, 2'b10);
            tick();
            chk("trap_t2b", {mem_en, ldMDR}, 2'b10);
            tick();
            chk("trap_t2c_wait", {mem_en, ldMDR}, 2'b10);
            mem_ready = 1'b1;
            #1;
            chk("trap_t2c_ready", {mem_en, ldMDR, mem_err}, 3'b110);
            tick();
            chk("trap_t3", {ldPC, selPC, gateMDR}, 4'b1101);
        end

        // Fetch timeout with memory never ready
        begin
            logic hit;
            int f1_n, err_at, mdr_n;
            do_reset();
            mem_ready = 1'b0;
            run       = 1'b1;
            hit       = 1'b0;
            for (int i = 0; i < 10 && !hit; i++) begin
                tick();
                if (mem_en) hit = 1'b1;
            end
            chk("tmo_f1_seen", hit, 1);
            f1_n = 0; err_at = 0; mdr_n = 0;
            while (mem_en && f1_n < 40) begin
                f1_n++;
                if (mem_err) err_at = f1_n;
                mdr_n += int'(ldMDR);
                tick();
            end
            chk("tmo_f1_cycles", f1_n, 15);
            chk("tmo_err_cycle", err_at, 15);
            chk("tmo_no_ldmdr", mdr_n, 0);
            chk("tmo_idle_outs", 32'(outs), 0);
            chk("tmo_retired", 32'(retired), 0);
        end

        // mem_ready in the timeout cycle wins
        begin
            logic hit;
            do_reset();
            mem_ready = 1'b0;
            run       = 1'b1;
            hit       = 1'b0;
            for (int i = 0; i < 10 && !hit; i++) begin
                tick();
                if (mem_en) hit = 1'b1;
            end
            repeat (14) tick();
            chk("prio_err_pending", mem_err, 1);
            mem_ready = 1'b1;
            #1;
            chk("prio_no_err", {mem_err, ldMDR}, 2'b01);
            tick();
            chk("prio_f2", {gateMDR, ldIR}, 2'b11);
        end

        // run dropped during execute: instruction finishes then idles
        begin
            logic hit;
            int busy;
            do_reset();
            ir  = 16'h1021;
            run = 1'b1;
            wait_for_start("halt_exec_start");
            run = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < 10 && !hit; i++) begin
                tick();
                if (retired == 16'd1) hit = 1'b1;
            end
            chk("halt_retired", hit, 1);
            busy = 0;
            repeat (4) begin
                busy += int'(outs != '0);
                tick();
            end
            chk("halt_idle", busy, 0);
        end

        // Retired counter wraps (3-bit instance)
        begin
            logic hit;
            do_reset();
            ir  = 16'hC1C0;
            run = 1'b1;
            hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                tick();
                if (w_retired == 3'd7) hit = 1'b1;
            end
            chk("wrap_reach7", hit, 1);
            chk("wrap_main7", 32'(retired), 7);
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                tick();
                if (w_retired != 3'd7) hit = 1'b1;
            end
            chk("wrap_change", hit, 1);
            chk("wrap_zero", 32'(w_retired), 0);
            chk("wrap_main8", 32'(retired), 8);
        end

        // Asynchronous reset in EW of the second instruction
        begin
            do_reset();
            ir  = 16'h1021;
            run = 1'b1;
            wait_for_start("arst_first");
            wait_for_start("arst_second");
            chk("arst_retired_pre", 32'(retired), 1);
            tick();
            #2;
            reset = 1'b1;
            #1;
            chk("arst_outs", 32'(outs), 0);
            chk("arst_retired", 32'(retired), 0);
            @(negedge clk);
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
